// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, 8 data bits LSB first, optional parity, stop.
// Build option: define UART_TX_TWO_STOP_EN for two stop bits.
module uart_tx (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [1:0]  i_parity,
  input  logic [15:0] i_div,
  input  logic [7:0]  i_tx_data,
  input  logic        i_tx_start,
  output logic        o_tx_busy,
  output logic        o_tx_int,
  input  logic        i_tx_ack,
  output logic        o_uart_txd
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_next;
  logic [15:0] r_div;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_next;
  logic [7:0]  r_data;
  logic [1:0]  r_parity;
  logic        r_txd;
  logic        r_busy;
  logic        r_int;
  logic        w_txd_next;
  logic        w_accept;
  logic        w_bit_end;
  logic        w_done;
`ifdef UART_TX_TWO_STOP_EN
  logic        r_stop2;
  logic        w_stop2_next;
`endif

  assign w_accept  = (r_state == S_IDLE) && i_tx_start;
  assign w_bit_end = (r_cnt == r_div);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_done       = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
    w_stop2_next = r_stop2;
`endif
    if (r_state == S_IDLE) begin
      if (i_tx_start) begin
        w_state_next = S_START;
        w_cnt_next   = 16'd0;
        w_idx_next   = 3'd0;
`ifdef UART_TX_TWO_STOP_EN
        w_stop2_next = 1'b0;
`endif
      end
    end else if (!w_bit_end) begin
      w_cnt_next = r_cnt + 16'd1;
    end else begin
      w_cnt_next = 16'd0;
      case (r_state)
        S_START: begin
          w_state_next = S_DATA;
          w_idx_next   = 3'd0;
        end
        S_DATA: begin
          if (r_idx == 3'd7) begin
            w_state_next = r_parity[1] ? S_PARITY : S_STOP;
          end else begin
            w_idx_next = r_idx + 3'd1;
          end
        end
        S_PARITY: w_state_next = S_STOP;
        S_STOP: begin
`ifdef UART_TX_TWO_STOP_EN
          if (!r_stop2) begin
            w_stop2_next = 1'b1;
          end else begin
            w_state_next = S_IDLE;
            w_done       = 1'b1;
          end
`else
          w_state_next = S_IDLE;
          w_done       = 1'b1;
`endif
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Line level is registered from the next state so txd changes on the same edge as the state.
  always_comb begin
    w_txd_next = 1'b1;
    case (w_state_next)
      S_START:  w_txd_next = 1'b0;
      S_DATA:   w_txd_next = r_data[w_idx_next];
      S_PARITY: w_txd_next = (^r_data) ^ r_parity[0];
      default:  w_txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 16'd0;
      r_idx    <= 3'd0;
      r_div    <= 16'd0;
      r_data   <= 8'd0;
      r_parity <= 2'd0;
      r_txd    <= 1'b1;
      r_busy   <= 1'b0;
      r_int    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      r_stop2  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_txd   <= w_txd_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_int   <= w_done ? 1'b1 : (i_tx_ack ? 1'b0 : r_int);
`ifdef UART_TX_TWO_STOP_EN
      r_stop2 <= w_stop2_next;
`endif
      if (w_accept) begin
        r_data   <= i_tx_data;
        r_div    <= i_div;
        r_parity <= i_parity;
      end
    end
  end

  assign o_uart_txd = r_txd;
  assign o_tx_busy  = r_busy;
  assign o_tx_int   = r_int;

endmodule
